// File: rtl/alu_issuer.sv
// ALU command issuer: queues commands in a FIFO, drives the ALU ACT/RDY/VLD handshake
// one command at a time and returns a 64-bit tagged result on a valid/ready stream.
module alu_issuer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    CMD_VLD,
  output logic                    CMD_RDY,
  input  logic [3:0]              CMD_OP,
  input  logic [1:0]              CMD_MOVI,
  input  logic [31:0]             CMD_REG_A,
  input  logic [31:0]             CMD_REG_B,
  input  logic [31:0]             CMD_MEM,
  input  logic [31:0]             CMD_IMM,
  input  logic [TAG_W-1:0]        CMD_TAG,
  output logic                    ALU_ACT,
  output logic [3:0]              ALU_OP,
  output logic [1:0]              ALU_MOVI,
  output logic [31:0]             ALU_REG_A,
  output logic [31:0]             ALU_REG_B,
  output logic [31:0]             ALU_MEM,
  output logic [31:0]             ALU_IMM,
  input  logic                    ALU_RDY,
  input  logic                    ALU_VLD,
  input  logic [31:0]             ALU_DATA,
  output logic                    RES_VLD,
  input  logic                    RES_RDY,
  output logic [63:0]             RES_DATA,
  output logic [TAG_W-1:0]        RES_TAG,
  output logic                    RES_MUL,
  output logic                    RES_ERR,
  output logic [$clog2(DEPTH):0]  COUNT
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);
  localparam logic [3:0]  OP_MUL = 4'b0010;

  typedef struct packed {
    logic [3:0]       op;
    logic [1:0]       movi;
    logic [31:0]      reg_a;
    logic [31:0]      reg_b;
    logic [31:0]      mem;
    logic [31:0]      imm;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT_LO = 3'd2,
    WAIT_HI = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             act_q, act_d;
  logic             res_vld_q, res_vld_d;
  logic             abort;

  cmd_t             fifo_q [DEPTH];
  cmd_t             cmd_in, head, alu_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             cmd_rdy_q;
  logic             push, pop;

  logic [TMO_W-1:0] tmo_q;
  logic             timed, tmo_hit, enter_done;
  logic             spur_vld, spur_q, is_mul;
  logic [31:0]      lo_q;
  logic [63:0]      res_data_q;
  logic [TAG_W-1:0] res_tag_q;
  logic             res_mul_q, res_err_q;

  assign cmd_in = '{op: CMD_OP, movi: CMD_MOVI, reg_a: CMD_REG_A, reg_b: CMD_REG_B,
                    mem: CMD_MEM, imm: CMD_IMM, tag: CMD_TAG};
  assign head   = fifo_q[rd_ptr_q];

  assign push    = CMD_VLD && cmd_rdy_q;
  assign pop     = (state_q == IDLE) && (count_q != '0) && !res_vld_q;
  assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

  assign is_mul     = (alu_q.op == OP_MUL);
  assign timed      = (state_q == ISSUE) || (state_q == WAIT_LO) || (state_q == WAIT_HI);
  assign tmo_hit    = timed && (tmo_q == TMO_W'(TIMEOUT - 1));
  assign enter_done = (state_d == DONE) && (state_q != DONE);
  // A result beat outside the data-collecting states is flagged, never captured
  assign spur_vld   = ALU_VLD && ((state_q == IDLE) || (state_q == ISSUE) || (state_q == DONE));

  // Command FIFO storage
  always_ff @(posedge CLK) begin
    if (push) fifo_q[wr_ptr_q] <= cmd_in;
  end

  // FIFO pointers, occupancy and registered ready
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      cmd_rdy_q <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q   <= count_d;
      cmd_rdy_q <= (count_d != CNT_W'(DEPTH));
    end
  end

  // FSM state register together with its registered handshake outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      act_q     <= 1'b0;
      res_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      act_q     <= act_d;
      res_vld_q <= res_vld_d;
    end
  end

  // Next-state logic; abort marks a timeout exit into DONE
  always_comb begin
    state_d = state_q;
    abort   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop) state_d = ISSUE;
      end
      ISSUE: begin
        if (ALU_RDY) begin
          state_d = WAIT_LO;
        end else if (tmo_hit) begin
          state_d = DONE;
          abort   = 1'b1;
        end
      end
      WAIT_LO: begin
        if (ALU_VLD) begin
          state_d = is_mul ? WAIT_HI : DONE;
        end else if (tmo_hit) begin
          state_d = DONE;
          abort   = 1'b1;
        end
      end
      WAIT_HI: begin
        if (ALU_VLD) begin
          state_d = DONE;
        end else if (tmo_hit) begin
          state_d = DONE;
          abort   = 1'b1;
        end
      end
      DONE: begin
        if (RES_RDY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the upcoming state so ACT/RES_VLD register alongside it
  always_comb begin
    act_d     = 1'b0;
    res_vld_d = 1'b0;
    if (state_d == ISSUE) act_d     = 1'b1;
    if (state_d == DONE)  res_vld_d = 1'b1;
  end

  // Issued command fields, held from the pop until the next pop
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      alu_q <= '0;
      lo_q  <= '0;
    end else begin
      if (pop) alu_q <= head;
      if ((state_q == WAIT_LO) && ALU_VLD) lo_q <= ALU_DATA;
    end
  end

  // Timeout counter and pending spurious-beat flag
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tmo_q  <= '0;
      spur_q <= 1'b0;
    end else begin
      if (state_d != state_q) tmo_q <= '0;
      else if (timed)         tmo_q <= tmo_q + TMO_W'(1);
      if (spur_vld)           spur_q <= 1'b1;
      else if (enter_done)    spur_q <= 1'b0;
    end
  end

  // Result capture on entry to DONE; errored results carry zero data
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      res_data_q <= '0;
      res_tag_q  <= '0;
      res_mul_q  <= 1'b0;
      res_err_q  <= 1'b0;
    end else if (enter_done) begin
      res_tag_q <= alu_q.tag;
      res_mul_q <= is_mul;
      res_err_q <= abort || spur_q;
      if (abort || spur_q)         res_data_q <= '0;
      else if (state_q == WAIT_HI) res_data_q <= {ALU_DATA, lo_q};
      else                         res_data_q <= {32'h0, ALU_DATA};
    end
  end

  assign CMD_RDY   = cmd_rdy_q;
  assign COUNT     = count_q;
  assign ALU_ACT   = act_q;
  assign ALU_OP    = alu_q.op;
  assign ALU_MOVI  = alu_q.movi;
  assign ALU_REG_A = alu_q.reg_a;
  assign ALU_REG_B = alu_q.reg_b;
  assign ALU_MEM   = alu_q.mem;
  assign ALU_IMM   = alu_q.imm;
  assign RES_VLD   = res_vld_q;
  assign RES_DATA  = res_data_q;
  assign RES_TAG   = res_tag_q;
  assign RES_MUL   = res_mul_q;
  assign RES_ERR   = res_err_q;

endmodule

// File: tb/tb_alu_issuer.sv
// Directed bench for alu_issuer with a simple behavioural ALU responder.
module tb_alu_issuer;

  logic        clk, rst_n;
  logic        cmd_vld, cmd_rdy;
  logic [3:0]  cmd_op;
  logic [1:0]  cmd_movi;
  logic [31:0] cmd_reg_a, cmd_reg_b, cmd_mem, cmd_imm;
  logic [3:0]  cmd_tag;
  logic        alu_act;
  logic [3:0]  alu_op;
  logic [1:0]  alu_movi;
  logic [31:0] alu_reg_a, alu_reg_b, alu_mem, alu_imm;
  logic        alu_rdy, alu_vld;
  logic [31:0] alu_data;
  logic        res_vld, res_rdy, res_mul, res_err;
  logic [63:0] res_data;
  logic [3:0]  res_tag;
  logic [2:0]  count;

  // Responder drives m_*, directed steps drive f_* for forced beats
  logic        alu_auto, m_vld, f_vld;
  logic [31:0] m_data, f_data;
  logic [31:0] mb;
  logic [63:0] mres;
  logic        mmul;

  int n_chk, n_pass, n_fail, acc, act_cyc;

  assign alu_vld  = m_vld | f_vld;
  assign alu_data = f_vld ? f_data : m_data;

  alu_issuer #(.DEPTH(4), .TAG_W(4), .TIMEOUT(16)) dut (
    .CLK(clk), .RST_N(rst_n),
    .CMD_VLD(cmd_vld), .CMD_RDY(cmd_rdy), .CMD_OP(cmd_op), .CMD_MOVI(cmd_movi),
    .CMD_REG_A(cmd_reg_a), .CMD_REG_B(cmd_reg_b), .CMD_MEM(cmd_mem), .CMD_IMM(cmd_imm),
    .CMD_TAG(cmd_tag),
    .ALU_ACT(alu_act), .ALU_OP(alu_op), .ALU_MOVI(alu_movi), .ALU_REG_A(alu_reg_a),
    .ALU_REG_B(alu_reg_b), .ALU_MEM(alu_mem), .ALU_IMM(alu_imm),
    .ALU_RDY(alu_rdy), .ALU_VLD(alu_vld), .ALU_DATA(alu_data),
    .RES_VLD(res_vld), .RES_RDY(res_rdy), .RES_DATA(res_data), .RES_TAG(res_tag),
    .RES_MUL(res_mul), .RES_ERR(res_err), .COUNT(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Behavioural ALU: one-cycle lo beat, MUL adds a hi beat
  initial begin
    m_vld  = 1'b0;
    m_data = '0;
    forever begin
      @(negedge clk);
      if (alu_auto && alu_act && alu_rdy) begin
        case (alu_movi)
          2'd0:    mb = alu_reg_b;
          2'd1:    mb = alu_mem;
          default: mb = alu_imm;
        endcase
        mmul = (alu_op == 4'b0010);
        if (mmul) mres = 64'(alu_reg_a) * 64'(mb);
        else      mres = {32'h0, alu_reg_a + mb};
        @(posedge clk); #1;
        m_vld  = 1'b1;
        m_data = mres[31:0];
        if (mmul) begin
          @(posedge clk); #1;
          m_data = mres[63:32];
        end
        @(posedge clk); #1;
        m_vld = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [1:0] movi, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] m, input logic [31:0] i,
                      input logic [3:0] tag);
    cmd_op = op; cmd_movi = movi; cmd_reg_a = a; cmd_reg_b = b;
    cmd_mem = m; cmd_imm = i; cmd_tag = tag; cmd_vld = 1'b1;
    @(posedge clk); #1;
    cmd_vld = 1'b0;
  endtask

  task automatic expect_res(input string name, input logic [3:0] tag, input logic [63:0] data,
                            input logic mul, input logic err);
    int n;
    n = 0;
    while (!res_vld && n < 40) begin
      tick();
      n++;
    end
    chk({name, " vld"}, 64'(res_vld), 64'd1);
    if (res_vld) begin
      chk({name, " tag"}, 64'(res_tag), 64'(tag));
      chk({name, " data"}, res_data, data);
      chk({name, " mul"}, 64'(res_mul), 64'(mul));
      chk({name, " err"}, 64'(res_err), 64'(err));
    end
    tick();
  endtask

  initial begin
    n_chk = 0; n_pass = 0; n_fail = 0;
    rst_n = 1'b0; cmd_vld = 1'b0; cmd_op = '0; cmd_movi = '0; cmd_reg_a = '0;
    cmd_reg_b = '0; cmd_mem = '0; cmd_imm = '0; cmd_tag = '0;
    alu_rdy = 1'b1; res_rdy = 1'b1; alu_auto = 1'b1; f_vld = 1'b0; f_data = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst cmd_rdy", 64'(cmd_rdy), 64'd1);
    chk("rst count", 64'(count), 64'd0);
    chk("rst act", 64'(alu_act), 64'd0);
    chk("rst res_vld", 64'(res_vld), 64'd0);
    chk("rst res_data", res_data, 64'd0);
    chk("rst alu_reg_a", 64'(alu_reg_a), 64'd0);
    rst_n = 1'b1;
    tick();

    // ADD latency: accepted at edge t
    send(4'd0, 2'd0, 32'd5, 32'd7, 32'd0, 32'd0, 4'd3);
    chk("add act t+1", 64'(alu_act), 64'd0);
    tick();
    chk("add act t+2", 64'(alu_act), 64'd1);
    chk("add reg_a", 64'(alu_reg_a), 64'd5);
    tick();
    chk("add vld t+3", 64'(res_vld), 64'd0);
    tick();
    chk("add vld t+4", 64'(res_vld), 64'd1);
    chk("add data", res_data, 64'd12);
    chk("add tag", 64'(res_tag), 64'd3);
    chk("add mul", 64'(res_mul), 64'd0);
    chk("add err", 64'(res_err), 64'd0);
    tick();
    chk("add vld t+5", 64'(res_vld), 64'd0);

    // MUL latency
    send(4'd2, 2'd2, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd2, 4'd5);
    repeat (3) tick();
    chk("mul vld t+4", 64'(res_vld), 64'd0);
    tick();
    chk("mul vld t+5", 64'(res_vld), 64'd1);
    chk("mul data", res_data, 64'h1_FFFF_FFFE);
    chk("mul flag", 64'(res_mul), 64'd1);
    chk("mul tag", 64'(res_tag), 64'd5);
    chk("mul err", 64'(res_err), 64'd0);
    tick();

    // Backpressure: six back-to-back commands, result stream stalled
    res_rdy = 1'b0;
    acc = 0;
    for (int i = 1; i <= 6; i++) begin
      cmd_op = 4'd0; cmd_movi = 2'd0; cmd_reg_a = 32'(i * 10); cmd_reg_b = 32'd1;
      cmd_tag = 4'(i); cmd_vld = 1'b1;
      if (cmd_rdy) acc++;
      tick();
    end
    cmd_vld = 1'b0;
    chk("bp accepted", 64'(acc), 64'd5);
    chk("bp cmd_rdy", 64'(cmd_rdy), 64'd0);
    chk("bp count", 64'(count), 64'd4);
    res_rdy = 1'b1;
    expect_res("bp r1", 4'd1, 64'd11, 1'b0, 1'b0);
    expect_res("bp r2", 4'd2, 64'd21, 1'b0, 1'b0);
    expect_res("bp r3", 4'd3, 64'd31, 1'b0, 1'b0);
    expect_res("bp r4", 4'd4, 64'd41, 1'b0, 1'b0);
    expect_res("bp r5", 4'd5, 64'd51, 1'b0, 1'b0);
    chk("bp count drained", 64'(count), 64'd0);
    repeat (8) tick();
    chk("bp no 6th", 64'(res_vld), 64'd0);

    // ALU_RDY low for three ISSUE cycles
    alu_rdy = 1'b0;
    act_cyc = 0;
    send(4'd1, 2'd1, 32'd100, 32'd0, 32'd23, 32'd0, 4'd7);
    for (int c = 0; c < 3; c++) begin
      tick();
      act_cyc += int'(alu_act);
      chk("stall reg_a", 64'(alu_reg_a), 64'd100);
      chk("stall mem", 64'(alu_mem), 64'd23);
    end
    tick();
    alu_rdy = 1'b1;
    act_cyc += int'(alu_act);
    tick();
    chk("stall act cycles", 64'(act_cyc), 64'd4);
    chk("stall act dropped", 64'(alu_act), 64'd0);
    chk("stall hold op", 64'(alu_op), 64'd1);
    expect_res("stall res", 4'd7, 64'd123, 1'b0, 1'b0);

    // Timeout: no result beat ever arrives
    alu_auto = 1'b0;
    send(4'd0, 2'd0, 32'd1, 32'd2, 32'd0, 32'd0, 4'd9);
    repeat (17) tick();
    chk("tmo vld t+18", 64'(res_vld), 64'd0);
    tick();
    chk("tmo vld t+19", 64'(res_vld), 64'd1);
    chk("tmo err", 64'(res_err), 64'd1);
    chk("tmo data", res_data, 64'd0);
    chk("tmo tag", 64'(res_tag), 64'd9);
    tick();
    alu_auto = 1'b1;
    send(4'd0, 2'd0, 32'd20, 32'd22, 32'd0, 32'd0, 4'd10);
    expect_res("post tmo", 4'd10, 64'd42, 1'b0, 1'b0);

    // Spurious beat while idle poisons only the next result
    f_data = 32'hDEAD_BEEF;
    f_vld  = 1'b1;
    tick();
    f_vld  = 1'b0;
    send(4'd0, 2'd0, 32'd3, 32'd4, 32'd0, 32'd0, 4'd11);
    expect_res("spur", 4'd11, 64'd0, 1'b0, 1'b1);
    send(4'd0, 2'd0, 32'd3, 32'd4, 32'd0, 32'd0, 4'd12);
    expect_res("post spur", 4'd12, 64'd7, 1'b0, 1'b0);

    // Reset while waiting for the MUL hi beat with two commands queued
    alu_auto = 1'b0;
    send(4'd2, 2'd0, 32'd6, 32'd7, 32'd0, 32'd0, 4'd1);
    send(4'd0, 2'd0, 32'd1, 32'd1, 32'd0, 32'd0, 4'd2);
    send(4'd0, 2'd0, 32'd2, 32'd2, 32'd0, 32'd0, 4'd3);
    f_data = 32'd42;
    f_vld  = 1'b1;
    tick();
    f_vld  = 1'b0;
    chk("rst6 count before", 64'(count), 64'd2);
    chk("rst6 res_vld before", 64'(res_vld), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("rst6 act", 64'(alu_act), 64'd0);
    chk("rst6 res_vld", 64'(res_vld), 64'd0);
    chk("rst6 count", 64'(count), 64'd0);
    chk("rst6 cmd_rdy", 64'(cmd_rdy), 64'd1);
    tick();
    rst_n = 1'b1;
    alu_auto = 1'b1;
    tick();
    send(4'd0, 2'd0, 32'd8, 32'd9, 32'd0, 32'd0, 4'd4);
    expect_res("post rst", 4'd4, 64'd17, 1'b0, 1'b0);
    repeat (10) tick();
    chk("post rst idle", 64'(res_vld), 64'd0);
    chk("post rst count", 64'(count), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
